// File: rtl/camera_controller.sv
// camera_controller: buttons/switches -> camera position and fractal select.
// Ports: clk_in, rst_in (async active-low), btnl/btnr/btnu/btnd, sw[15:0],
//   new_frame_in; pos_x/y/z_out (signed fixed point), fractal_sel_out,
//   moving_out. Position/select change only on a new_frame_in rising edge.
module camera_controller #(
    parameter int                  FP_WIDTH  = 32,
    parameter int                  DB_COUNT  = 500000,
    parameter logic [FP_WIDTH-1:0] BASE_STEP = FP_WIDTH'(32'h0000_0400),
    parameter logic [FP_WIDTH-1:0] POS_LIMIT = FP_WIDTH'(32'h0008_0000),
    parameter logic [FP_WIDTH-1:0] INIT_X    = FP_WIDTH'(32'h0000_0000),
    parameter logic [FP_WIDTH-1:0] INIT_Y    = FP_WIDTH'(32'h0001_0000),
    parameter logic [FP_WIDTH-1:0] INIT_Z    = FP_WIDTH'(32'hFFFE_8000)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                btnl,
    input  logic                btnr,
    input  logic                btnu,
    input  logic                btnd,
    input  logic [15:0]         sw,
    input  logic                new_frame_in,
    output logic [FP_WIDTH-1:0] pos_x_out,
    output logic [FP_WIDTH-1:0] pos_y_out,
    output logic [FP_WIDTH-1:0] pos_z_out,
    output logic [1:0]          fractal_sel_out,
    output logic                moving_out
);

    localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [CW-1:0] DB_MAX = CW'(DB_COUNT - 1);
    localparam logic signed [FP_WIDTH:0] LIM_P = {1'b0, POS_LIMIT};
    localparam logic signed [FP_WIDTH:0] LIM_N = -LIM_P;

    // Button order: 0=left, 1=right, 2=up, 3=down.
    logic [3:0]    btn_s1, btn_s2, db;
    logic [4:0]    sw_s1, sw_s2;
    logic [CW-1:0] cnt [4];
    logic          nf_q;
    logic          frame_evt;
    logic          unused_sw;

    logic signed [FP_WIDTH-1:0] pos_x, pos_y, pos_z;
    logic signed [FP_WIDTH-1:0] step, nx_x, nx_v;

    assign unused_sw = ^sw[15:5];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
            nf_q   <= 1'b0;
        end else begin
            btn_s1 <= {btnd, btnu, btnr, btnl};
            btn_s2 <= btn_s1;
            sw_s1  <= sw[4:0];
            sw_s2  <= sw_s1;
            nf_q   <= new_frame_in;
        end
    end

    // A change must persist for DB_COUNT consecutive cycles to be accepted.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            db <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btn_s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_MAX) begin
                    db[i]  <= ~db[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign frame_evt = new_frame_in & ~nf_q;
    assign step      = BASE_STEP << sw_s2[1:0];

    // One-axis move with sign-extended sum and symmetric clamp.
    function automatic logic signed [FP_WIDTH-1:0] move(
        input logic signed [FP_WIDTH-1:0] p,
        input logic                       up,
        input logic                       dn,
        input logic signed [FP_WIDTH-1:0] st
    );
        logic signed [FP_WIDTH:0] sum;
        sum = {p[FP_WIDTH-1], p};
        if (up && !dn)
            sum = sum + {st[FP_WIDTH-1], st};
        else if (dn && !up)
            sum = sum - {st[FP_WIDTH-1], st};
        if (sum > LIM_P)
            move = LIM_P[FP_WIDTH-1:0];
        else if (sum < LIM_N)
            move = LIM_N[FP_WIDTH-1:0];
        else
            move = sum[FP_WIDTH-1:0];
    endfunction

    // Debounced state is read before any flip on this edge.
    always_comb begin
        nx_x = move(pos_x, db[1], db[0], step);
        nx_v = move(sw_s2[2] ? pos_y : pos_z, db[2], db[3], step);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pos_x           <= INIT_X;
            pos_y           <= INIT_Y;
            pos_z           <= INIT_Z;
            fractal_sel_out <= 2'b00;
            moving_out      <= 1'b0;
        end else begin
            moving_out <= |db;
            if (frame_evt) begin
                pos_x           <= nx_x;
                fractal_sel_out <= sw_s2[4:3];
                if (sw_s2[2])
                    pos_y <= nx_v;
                else
                    pos_z <= nx_v;
            end
        end
    end

    assign pos_x_out = pos_x;
    assign pos_y_out = pos_y;
    assign pos_z_out = pos_z;

endmodule

// File: tb/tb_camera_controller.sv
// tb_camera_controller: directed stimulus with a queue-based scoreboard.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_camera_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btnl = 0, btnr = 0, btnu = 0, btnd = 0;
    logic [15:0] sw = '0;
    logic        new_frame = 1'b0;
    logic [31:0] px, py, pz;
    logic [1:0]  sel;
    logic        mov;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] x, y, z;
        logic [1:0]  sel;
        logic        mov;
    } exp_t;

    exp_t q[$];

    localparam logic [31:0] RX = 32'h0000_0000;
    localparam logic [31:0] RY = 32'h0001_0000;
    localparam logic [31:0] RZ = 32'hFFFE_8000;

    always #5 clk = ~clk;

    camera_controller #(.DB_COUNT(4)) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .btnl            (btnl),
        .btnr            (btnr),
        .btnu            (btnu),
        .btnd            (btnd),
        .sw              (sw),
        .new_frame_in    (new_frame),
        .pos_x_out       (px),
        .pos_y_out       (py),
        .pos_z_out       (pz),
        .fractal_sel_out (sel),
        .moving_out      (mov)
    );

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({px, py, pz, sel, mov} !== {e.x, e.y, e.z, e.sel, e.mov}) begin
                errors++;
                $display("FAIL %s: got x=%h y=%h z=%h sel=%0d mov=%b want x=%h y=%h z=%h sel=%0d mov=%b",
                         e.name, px, py, pz, sel, mov, e.x, e.y, e.z, e.sel, e.mov);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        new_frame = 1'b1;
        tick(1);
        new_frame = 1'b0;
        tick(1);
    endtask

    task automatic expect_out(input string n, input logic [31:0] x,
                              input logic [31:0] y, input logic [31:0] z,
                              input logic [1:0] s, input logic m);
        exp_t e;
        e.name = n;
        e.x = x;
        e.y = y;
        e.z = z;
        e.sel = s;
        e.mov = m;
        q.push_back(e);
    endtask

    initial begin
        logic signed [31:0] mx, mz;

        tick(3);
        expect_out("in_reset", RX, RY, RZ, 0, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        repeat (3) pulse();
        expect_out("idle_frames", RX, RY, RZ, 0, 0);
        tick(1);

        btnr = 1;
        tick(20);
        expect_out("btnr_pre_frame", RX, RY, RZ, 0, 1);
        tick(1);
        pulse();
        expect_out("btnr_step", 32'h400, RY, RZ, 0, 1);
        btnr = 0;
        tick(20);
        expect_out("btnr_release", 32'h400, RY, RZ, 0, 0);
        tick(1);

        sw = 16'h0007;
        btnu = 1;
        tick(20);
        pulse();
        pulse();
        expect_out("btnu_vert_x8", 32'h400, 32'h14000, RZ, 0, 1);
        btnd = 1;
        tick(20);
        pulse();
        expect_out("btnu_btnd_both", 32'h400, 32'h14000, RZ, 0, 1);
        btnu = 0;
        btnd = 0;
        tick(20);
        expect_out("ud_release", 32'h400, 32'h14000, RZ, 0, 0);
        tick(1);

        for (int i = 0; i < 3; i++) begin
            btnl = 1;
            tick(2);
            btnl = 0;
            expect_out("glitch_mov", 32'h400, 32'h14000, RZ, 0, 0);
            tick(4);
            pulse();
            expect_out("glitch_frame", 32'h400, 32'h14000, RZ, 0, 0);
            tick(1);
        end

        sw = 16'h0003;
        btnu = 1;
        btnl = 1;
        tick(20);
        mx = 32'sh400;
        mz = 32'shFFFE_8000;
        for (int i = 0; i < 300; i++) begin
            pulse();
            mx = (mx - 32'sh2000 < -32'sh8_0000) ? -32'sh8_0000 : mx - 32'sh2000;
            mz = (mz + 32'sh2000 > 32'sh8_0000) ? 32'sh8_0000 : mz + 32'sh2000;
            expect_out("saturate", mx, 32'h14000, mz, 0, 1);
        end
        expect_out("sat_final", 32'hFFF8_0000, 32'h14000, 32'h0008_0000, 0, 1);
        tick(1);

        btnu = 0;
        btnl = 0;
        btnd = 1;
        tick(20);
        new_frame = 1'b1;
        tick(10);
        new_frame = 1'b0;
        expect_out("held_frame_once", 32'hFFF8_0000, 32'h14000, 32'h0007_E000, 0, 1);
        tick(3);
        expect_out("held_frame_hold", 32'hFFF8_0000, 32'h14000, 32'h0007_E000, 0, 1);
        tick(1);
        btnd = 0;
        tick(20);

        sw = 16'h0010;
        tick(6);
        expect_out("sel_mid_frame", 32'hFFF8_0000, 32'h14000, 32'h0007_E000, 0, 0);
        tick(1);
        pulse();
        expect_out("sel_after_frame", 32'hFFF8_0000, 32'h14000, 32'h0007_E000, 2, 0);
        tick(1);

        btnr = 1;
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", RX, RY, RZ, 0, 0);
        tick(3);
        expect_out("reset_hold", RX, RY, RZ, 0, 0);
        tick(1);
        btnr = 0;
        rst_n = 1'b1;
        tick(3);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
